decode_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage for the 16-bit single-cycle-to-pipelined CPU migration. It extracts and registers opcode and register fields, the destination register, and the sign-extended immediate behind a valid/ready handshake with a two-entry skid buffer. It optionally inserts a load-use bubble and counts issued instructions. It sits between fetch (`in_*`) and the register-read/execute stage (`out_*`).

---
 rtl/decode_pkg.sv | 35 +++
 rtl/decode_if.sv | 48 ++++
 rtl/decode_skid.sv | 87 ++++++++
 rtl/decode_stage.sv | 143 ++++++++++++++
 tb/tb_decode_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, default field widths and the decoded
// instruction record shared by the decode stage and its users.
package decode_pkg;

   // Default geometry of the 16-bit ISA
   localparam int DEF_INSTR_W = 16;
   localparam int DEF_OPC_W   = 4;
   localparam int DEF_REG_W   = 3;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_PC_W    = 16;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_IMM_W   = DEF_INSTR_W - DEF_OPC_W - 2 * DEF_REG_W;
   localparam int DEF_FUNC_W  = DEF_IMM_W - DEF_REG_W;

   // Opcodes the decoder treats specially
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_LW    = 4'h8;
   localparam logic [3:0] OP_SW    = 4'hB;
   localparam logic [3:0] OP_BEQ   = 4'hC;

   // Decoded instruction record at the default geometry
   typedef struct packed {
      logic [DEF_OPC_W-1:0]  opcode;
      logic [DEF_REG_W-1:0]  rs;
      logic [DEF_REG_W-1:0]  rt;
      logic [DEF_REG_W-1:0]  rd;
      logic [DEF_FUNC_W-1:0] func;
      logic [DEF_REG_W-1:0]  dest;
      logic [DEF_DATA_W-1:0] imm_ext;
      logic                  is_rtype;
      logic                  reg_write;
      logic [DEF_PC_W-1:0]   pc;
   } decoded_t;

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake plus decoded fields of
// the decode stage. "slave" is the decode stage's view, "master" the
// view of the surrounding pipeline (fetch driving, execute consuming).
interface decode_if
   import decode_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int OPC_W   = DEF_OPC_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PC_W    = DEF_PC_W,
   parameter int CNT_W   = DEF_CNT_W
);
   localparam int FUNC_W = INSTR_W - OPC_W - 3 * REG_W;

   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [OPC_W-1:0]   opcode;
   logic [REG_W-1:0]   rs;
   logic [REG_W-1:0]   rt;
   logic [REG_W-1:0]   rd;
   logic [FUNC_W-1:0]  func;
   logic [REG_W-1:0]   dest;
   logic [DATA_W-1:0]  imm_ext;
   logic               is_rtype;
   logic               reg_write;
   logic               hazard_stall;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rs, rt, rd, func, dest,
             imm_ext, is_rtype, reg_write, hazard_stall, instr_count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, rs, rt, rd, func, dest,
             imm_ext, is_rtype, reg_write, hazard_stall, instr_count
   );

endinterface

// File: rtl/decode_skid.sv
// decode_skid: generic two-entry in-order valid/ready skid buffer.
// Push-ready is a registered "not full" so the upstream ready never
// depends combinationally on the downstream. Flush empties the buffer
// and discards a same-cycle push.
module decode_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push_valid,
   output logic         o_push_ready,
   input  logic [W-1:0] i_push_data,
   output logic         o_head_valid,
   input  logic         i_pop,
   output logic [W-1:0] o_head_data
);

   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         r_full;
   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_count_next;
   logic [W-1:0] w_entry [2];

   assign w_push = i_push_valid & ~r_full & ~i_flush;
   assign w_pop  = i_pop & (r_count != 2'd0) & ~i_flush;

   // Occupancy after this edge; flush wins over push and pop
   always_comb begin
      w_count_next = r_count;
      if (i_flush) begin
         w_count_next = 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
         endcase
      end
   end

   // Pointers, occupancy and the registered full flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_full   <= 1'b0;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
         end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == 2'd2);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [W-1:0] r_data;

         // Entry payload, cleared by reset so idle outputs read as zero
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data <= '0;
            end else if (w_push && (r_wr_ptr == 1'(gi))) begin
               r_data <= i_push_data;
            end
         end

         assign w_entry[gi] = r_data;
      end
   endgenerate

   assign o_push_ready = ~r_full;
   assign o_head_valid = (r_count != 2'd0);
   assign o_head_data  = w_entry[r_rd_ptr];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: splits a fetched instruction into opcode/register/imm
// fields, buffers the record in a two-entry skid buffer, and presents the
// head entry to register-read/execute. Counts issued instructions.
// Optional feature macro: DECODE_HAZARD_EN inserts one bubble when the
// instruction right after a load reads the load's destination register.
module decode_stage
   import decode_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int OPC_W   = DEF_OPC_W,
   parameter int REG_W   = DEF_REG_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PC_W    = DEF_PC_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic    clk,
   input  logic    rst,
   decode_if.slave bus
);

   localparam int IMM_W  = INSTR_W - OPC_W - 2 * REG_W;
   localparam int FUNC_W = IMM_W - REG_W;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] imm_ext;
      logic              is_rtype;
      logic              reg_write;
      logic [PC_W-1:0]   pc;
   } rec_t;

   logic [OPC_W-1:0]  w_opcode;
   logic [REG_W-1:0]  w_rt;
   logic [REG_W-1:0]  w_rd;
   logic [REG_W-1:0]  w_dest;
   logic [IMM_W-1:0]  w_imm;
   logic              w_is_rtype;
   rec_t              w_dec;
   rec_t              w_head;
   logic              w_head_valid;
   logic              w_bubble;
   logic              w_out_valid;
   logic              w_out_fire;
   logic [CNT_W-1:0]  r_instr_count;

   assign w_opcode   = bus.in_instr[INSTR_W-1 -: OPC_W];
   assign w_rt       = bus.in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
   assign w_rd       = bus.in_instr[IMM_W-1 -: REG_W];
   assign w_imm      = bus.in_instr[IMM_W-1:0];
   assign w_is_rtype = (w_opcode == OPC_W'(OP_RTYPE));
   assign w_dest     = w_is_rtype ? w_rd : w_rt;

   // Field decode of the incoming instruction into the buffered record
   always_comb begin
      w_dec           = '0;
      w_dec.opcode    = w_opcode;
      w_dec.rs        = bus.in_instr[INSTR_W-OPC_W-1 -: REG_W];
      w_dec.rt        = w_rt;
      w_dec.rd        = w_rd;
      w_dec.func      = bus.in_instr[FUNC_W-1:0];
      w_dec.dest      = w_dest;
      w_dec.is_rtype  = w_is_rtype;
      w_dec.imm_ext   = w_is_rtype ? '0 : {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
      w_dec.reg_write = (w_opcode != OPC_W'(OP_SW)) && (w_opcode != OPC_W'(OP_BEQ))
                        && (w_dest != '0);
      w_dec.pc        = bus.in_pc;
   end

   decode_skid #(
      .W ($bits(rec_t))
   ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (bus.flush),
      .i_push_valid (bus.in_valid),
      .o_push_ready (bus.in_ready),
      .i_push_data  (w_dec),
      .o_head_valid (w_head_valid),
      .i_pop        (w_out_fire),
      .o_head_data  (w_head)
   );

`ifdef DECODE_HAZARD_EN
   logic             r_pending;
   logic [REG_W-1:0] r_pend_reg;
   logic             w_uses_rt;
   logic             w_load_issue;

   assign w_uses_rt    = w_head.is_rtype | (w_head.opcode == OPC_W'(OP_SW))
                         | (w_head.opcode == OPC_W'(OP_BEQ));
   assign w_load_issue = w_out_fire & (w_head.opcode == OPC_W'(OP_LW))
                         & (w_head.dest != '0);
   assign w_bubble     = w_head_valid & r_pending
                         & ((w_head.rs == r_pend_reg) | (w_uses_rt & (w_head.rt == r_pend_reg)));

   // A load with a live destination arms the check for exactly one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending  <= 1'b0;
         r_pend_reg <= '0;
      end else if (bus.flush) begin
         r_pending  <= 1'b0;
      end else begin
         r_pending <= w_load_issue;
         if (w_load_issue) r_pend_reg <= w_head.dest;
      end
   end
`else
   assign w_bubble = 1'b0;
`endif

   assign w_out_valid = w_head_valid & ~w_bubble;
   assign w_out_fire  = w_out_valid & bus.out_ready;

   // Issued-instruction counter, wraps naturally, untouched by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_count <= '0;
      end else if (w_out_fire) begin
         r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign bus.out_valid    = w_out_valid;
   assign bus.hazard_stall = w_bubble;
   assign bus.instr_count  = r_instr_count;
   assign bus.out_pc       = w_head.pc;
   assign bus.opcode       = w_head.opcode;
   assign bus.rs           = w_head.rs;
   assign bus.rt           = w_head.rt;
   assign bus.rd           = w_head.rd;
   assign bus.func         = w_head.func;
   assign bus.dest         = w_head.dest;
   assign bus.imm_ext      = w_head.imm_ext;
   assign bus.is_rtype     = w_head.is_rtype;
   assign bus.reg_write    = w_head.reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against
// a queue-based model of the decode rules. Honours DECODE_HAZARD_EN.
module tb_decode_stage;
   import decode_pkg::*;

   localparam int CNT_W = 4;
`ifdef DECODE_HAZARD_EN
   localparam bit HAZ = 1'b1;
`else
   localparam bit HAZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_if #(.CNT_W(CNT_W)) bus ();

   decode_stage #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          failures = 0;
   decoded_t    q[$];
   bit          m_pending;
   logic [2:0]  m_pend_reg;
   int          m_count;
   logic [15:0] pc_seq;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Decode rules written as plain arithmetic on the instruction word
   function automatic decoded_t model_decode(logic [15:0] ins, logic [15:0] pc);
      decoded_t d;
      int imm;
      d.opcode   = 4'(ins >> 12);
      d.rs       = 3'(ins >> 9);
      d.rt       = 3'(ins >> 6);
      d.rd       = 3'(ins >> 3);
      d.func     = 3'(ins);
      d.is_rtype = (d.opcode == OP_RTYPE);
      d.dest     = d.is_rtype ? d.rd : d.rt;
      imm = int'(ins % 16'd64);
      if (imm >= 32) imm = imm - 64;
      d.imm_ext  = d.is_rtype ? 32'd0 : 32'(imm);
      d.reg_write = (d.opcode != OP_SW) && (d.opcode != OP_BEQ) && (d.dest != 3'd0);
      d.pc       = pc;
      return d;
   endfunction

   function automatic bit m_bubble();
      bit reads;
      if (!HAZ || !m_pending || q.size() == 0) return 1'b0;
      reads = (q[0].rs == m_pend_reg) ||
              ((q[0].is_rtype || q[0].opcode == OP_SW || q[0].opcode == OP_BEQ)
               && q[0].rt == m_pend_reg);
      return reads;
   endfunction

   // The per-cycle comparison of every meaningful output against the model
   task automatic compare_model();
      bit bub;
      bub = m_bubble();
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0 && !bub));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      chk("hazard_stall", 32'(bus.hazard_stall), 32'(bub));
      chk("instr_count", 32'(bus.instr_count), 32'(m_count));
      if (q.size() > 0) begin
         chk("opcode", 32'(bus.opcode), 32'(q[0].opcode));
         chk("rs", 32'(bus.rs), 32'(q[0].rs));
         chk("rt", 32'(bus.rt), 32'(q[0].rt));
         chk("rd", 32'(bus.rd), 32'(q[0].rd));
         chk("func", 32'(bus.func), 32'(q[0].func));
         chk("dest", 32'(bus.dest), 32'(q[0].dest));
         chk("imm_ext", bus.imm_ext, q[0].imm_ext);
         chk("is_rtype", 32'(bus.is_rtype), 32'(q[0].is_rtype));
         chk("reg_write", 32'(bus.reg_write), 32'(q[0].reg_write));
         chk("out_pc", 32'(bus.out_pc), 32'(q[0].pc));
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, compare
   task automatic step(bit v, logic [15:0] ins, bit ordy, bit fl);
      bit exp_ov, in_fire, out_fire;
      decoded_t head;
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc_seq;
      bus.out_ready = ordy;
      bus.flush     = fl;
      exp_ov   = (q.size() > 0) && !m_bubble();
      in_fire  = v && (q.size() < 2);
      out_fire = exp_ov && ordy;
      head = '0;
      if (out_fire) begin
         head = q.pop_front();
         m_count = (m_count + 1) % (1 << CNT_W);
         $display("xfer pc=%h op=%h dest=%0d imm=%h", head.pc, head.opcode, head.dest, head.imm_ext);
      end
      if (fl) begin
         q.delete();
         m_pending = 1'b0;
      end else begin
         m_pending = out_fire && head.opcode == OP_LW && head.dest != 3'd0;
         if (m_pending) m_pend_reg = head.dest;
         if (in_fire) q.push_back(model_decode(ins, pc_seq));
      end
      if (in_fire) pc_seq = pc_seq + 16'd1;
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic check_reset_values(string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_hazard"}, 32'(bus.hazard_stall), 32'd0);
      chk({tag, "_count"}, 32'(bus.instr_count), 32'd0);
      chk({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
      chk({tag, "_dest"}, 32'(bus.dest), 32'd0);
      chk({tag, "_imm"}, bus.imm_ext, 32'd0);
      chk({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.out_ready = 1'b0; bus.flush = 1'b0;
      q.delete(); m_pending = 1'b0; m_pend_reg = '0; m_count = 0;
      #1;
      check_reset_values("rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compare_model();
   endtask

   function automatic logic [15:0] rand_instr();
      logic [3:0] op;
      logic [15:0] w;
      case ($urandom_range(0, 4))
         0: op = OP_RTYPE;
         1: op = OP_LW;
         2: op = OP_SW;
         3: op = OP_BEQ;
         default: op = 4'($urandom_range(0, 15));
      endcase
      w = 16'($urandom);
      // Keep rs/rt small so load-use collisions are common
      return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), w[5:0]};
   endfunction

   initial begin
      logic [15:0] pc0;
      int saved;
      pc_seq = 16'd0;
      do_reset();

      // R-type decode
      step(1'b1, 16'h0298, 1'b1, 1'b0);
      chk("r_opcode", 32'(bus.opcode), 32'd0);
      chk("r_rs", 32'(bus.rs), 32'd1);
      chk("r_rt", 32'(bus.rt), 32'd2);
      chk("r_rd", 32'(bus.rd), 32'd3);
      chk("r_dest", 32'(bus.dest), 32'd3);
      chk("r_func", 32'(bus.func), 32'd0);
      chk("r_is_rtype", 32'(bus.is_rtype), 32'd1);
      chk("r_reg_write", 32'(bus.reg_write), 32'd1);
      chk("r_imm", bus.imm_ext, 32'd0);
      chk("r_valid", 32'(bus.out_valid), 32'd1);

      // Load decode (0x0298 issues on this edge)
      step(1'b1, 16'h82BF, 1'b1, 1'b0);
      chk("lw_opcode", 32'(bus.opcode), 32'h8);
      chk("lw_dest", 32'(bus.dest), 32'd2);
      chk("lw_imm", bus.imm_ext, 32'hFFFF_FFFF);
      chk("lw_reg_write", 32'(bus.reg_write), 32'd1);
      chk("lw_is_rtype", 32'(bus.is_rtype), 32'd0);

      // Load-use pair: 0x0458 reads r2
      step(1'b1, 16'h0458, 1'b1, 1'b0);
`ifdef DECODE_HAZARD_EN
      chk("lu_bubble_valid", 32'(bus.out_valid), 32'd0);
      chk("lu_bubble_stall", 32'(bus.hazard_stall), 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("lu_issue_valid", 32'(bus.out_valid), 32'd1);
      chk("lu_issue_rs", 32'(bus.rs), 32'd2);
`else
      chk("lu_nobubble_valid", 32'(bus.out_valid), 32'd1);
      chk("lu_nobubble_stall", 32'(bus.hazard_stall), 32'd0);
      chk("lu_nobubble_rs", 32'(bus.rs), 32'd2);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
`endif
      step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Backpressure: three offers, two accepted, head held
      pc0 = pc_seq;
      step(1'b1, 16'h0A98, 1'b0, 1'b0);
      step(1'b1, 16'h0CA0, 1'b0, 1'b0);
      step(1'b1, 16'h0EA8, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_pc_held", 32'(bus.out_pc), 32'(pc0));
      chk("bp_op_held", 32'(bus.rd), 32'd3);
      repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Flush with two entries and a simultaneous offer
      step(1'b1, 16'h0298, 1'b0, 1'b0);
      step(1'b1, 16'h0298, 1'b0, 1'b0);
      saved = m_count;
      step(1'b1, 16'h0298, 1'b0, 1'b1);
      chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
      chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
      chk("fl_count", 32'(bus.instr_count), 32'(saved));

      // Counter wrap: 17 transfers in a 4-bit counter
      do_reset();
      repeat (18) step(1'b1, 16'h0298, 1'b1, 1'b0);
      chk("wrap_count", 32'(bus.instr_count), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, rand_instr(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end

      // Asynchronous reset mid-stream
      step(1'b1, 16'h82BF, 1'b0, 1'b0);
      step(1'b1, 16'h0458, 1'b0, 1'b0);
      #2;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
